// File: rtl/shift_op_sequencer.sv
// Multi-cycle load/execute/capture controller around a combinational shifter.
// Optional result flags: define SHIFT_RESULT_FLAGS_EN.
module shift_op_sequencer #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        abort,
    input  logic [31:0] bus_in,
    input  logic        bus_valid,
    output logic        bus_ready,
    output logic [31:0] sh_a,
    output logic [31:0] sh_b,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    input  logic [31:0] sh_c,
    output logic [31:0] z_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        z_zero,
    output logic        z_neg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] z_q, z_d;
    logic        err_q, err_d;
    logic        cap;
    logic        exec;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = '0;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        err_d   = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op <= 3'd4) begin
                        op_d    = op;
                        state_d = S_LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD_A: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bus_valid) begin
                    a_d     = bus_in;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bus_valid) begin
                    b_d     = bus_in;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cap     = 1'b1;
                    z_d     = sh_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign exec      = (state_q == S_EXEC);
    assign SHR       = exec && (op_q == 3'd0);
    assign SHRA      = exec && (op_q == 3'd1);
    assign SHL       = exec && (op_q == 3'd2);
    assign ROR       = exec && (op_q == 3'd3);
    assign ROL       = exec && (op_q == 3'd4);
    assign bus_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign sh_a      = a_q;
    assign sh_b      = b_q;
    assign z_out     = z_q;

`ifdef SHIFT_RESULT_FLAGS_EN
    logic zz_q, zz_d;
    logic zn_q, zn_d;

    always_comb begin
        zz_d = zz_q;
        zn_d = zn_q;
        if (cap) begin
            zz_d = (sh_c == 32'd0);
            zn_d = sh_c[31];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            zz_q <= 1'b0;
            zn_q <= 1'b0;
        end else begin
            zz_q <= zz_d;
            zn_q <= zn_d;
        end
    end

    assign z_zero = zz_q;
    assign z_neg  = zn_q;
`else
    assign z_zero = 1'b0;
    assign z_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed bench for shift_op_sequencer with a behavioural shifter model.
// Covers EXEC_CYCLES=1 and EXEC_CYCLES=3 instances.
module tb_shift_op_sequencer;

    logic        clk;
    logic        clr;
    logic        start, start2;
    logic [2:0]  op;
    logic        abort;
    logic [31:0] bus_in;
    logic        bus_valid;

    logic        bus_ready, bus_ready2;
    logic [31:0] sh_a, sh_b, sh_c, z_out;
    logic [31:0] sh_a2, sh_b2, sh_c2, z_out2;
    logic        SHR, SHRA, SHL, ROR, ROL;
    logic        SHR2, SHRA2, SHL2, ROR2, ROL2;
    logic        busy, done, err, z_zero, z_neg;
    logic        busy2, done2, err2, z_zero2, z_neg2;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    function automatic logic [31:0] shf(
        input logic s_shr, s_shra, s_shl, s_ror, s_rol,
        input logic [31:0] a, b
    );
        logic [4:0] r;
        r = b[4:0];
        if (s_shr)  return (b >= 32) ? 32'd0 : a >> b;
        if (s_shra) return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
        if (s_shl)  return (b >= 32) ? 32'd0 : a << b;
        if (s_ror)  return (a >> r) | (a << (32 - r));
        if (s_rol)  return (a << r) | (a >> (32 - r));
        return 32'hDEAD_BEEF;
    endfunction

    assign sh_c  = shf(SHR, SHRA, SHL, ROR, ROL, sh_a, sh_b);
    assign sh_c2 = shf(SHR2, SHRA2, SHL2, ROR2, ROL2, sh_a2, sh_b2);

    shift_op_sequencer #(.EXEC_CYCLES(1)) u_dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .abort(abort),
        .bus_in(bus_in), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .sh_a(sh_a), .sh_b(sh_b),
        .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL),
        .sh_c(sh_c), .z_out(z_out), .busy(busy), .done(done), .err(err),
        .z_zero(z_zero), .z_neg(z_neg)
    );

    shift_op_sequencer #(.EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .clr(clr), .start(start2), .op(op), .abort(abort),
        .bus_in(bus_in), .bus_valid(bus_valid), .bus_ready(bus_ready2),
        .sh_a(sh_a2), .sh_b(sh_b2),
        .SHR(SHR2), .SHRA(SHRA2), .SHL(SHL2), .ROR(ROR2), .ROL(ROL2),
        .sh_c(sh_c2), .z_out(z_out2), .busy(busy2), .done(done2), .err(err2),
        .z_zero(z_zero2), .z_neg(z_neg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request; returns cycles from start edge to done and
    // the number of EXEC cycles with a strobe plus the last strobe vector.
    task automatic do_op(
        input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
        input int dly, output int cyc, output int nexec, output logic [4:0] strb
    );
        op = o;
        start = 1'b1;
        bus_valid = (dly == 0);
        bus_in = a;
        tick;
        start = 1'b0;
        cyc = 1;
        nexec = 0;
        strb = '0;
        for (int i = 0; i < dly; i++) begin
            chk("ready_wait", 32'(bus_ready), 32'd1);
            tick;
            cyc++;
        end
        bus_valid = 1'b1;
        tick;
        cyc++;
        bus_in = b;
        tick;
        cyc++;
        while (!done && cyc < 20) begin
            if ({SHR, SHRA, SHL, ROR, ROL} != 5'd0) begin
                nexec++;
                strb = {SHR, SHRA, SHL, ROR, ROL};
            end
            tick;
            cyc++;
        end
    endtask

    int         cyc, nexec;
    logic [4:0] strb;
    logic       exp_zero_f, exp_neg_f;
    int         done_at;

    initial begin
        clr = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        op = 3'd0;
        abort = 1'b0;
        bus_in = '0;
        bus_valid = 1'b0;
        #12;
        chk("rst_z", z_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(bus_ready), 32'd0);
        chk("rst_sha", sh_a, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        clr = 1'b0;
        tick;

        // SHRA 0x80000000 >>> 4
        do_op(3'd1, 32'h8000_0000, 32'd4, 0, cyc, nexec, strb);
        chk("shra_z", z_out, 32'hF800_0000);
        chk("shra_lat", 32'(cyc), 32'd4);
        chk("shra_nexec", 32'(nexec), 32'd1);
        chk("shra_strb", 32'(strb), 32'b01000);
        tick;
        chk("shra_done_1cyc", 32'(done), 32'd0);
        chk("shra_idle", 32'(busy), 32'd0);

        // SHR 0x80000000 >> 4
        do_op(3'd0, 32'h8000_0000, 32'd4, 0, cyc, nexec, strb);
        chk("shr_z", z_out, 32'h0800_0000);
        chk("shr_lat", 32'(cyc), 32'd4);
        chk("shr_strb", 32'(strb), 32'b10000);
        tick;

        // ROL 0x80000001 by 1 with 3-cycle bus delay
        do_op(3'd4, 32'h8000_0001, 32'd1, 3, cyc, nexec, strb);
        chk("rol_z", z_out, 32'h0000_0003);
        chk("rol_lat", 32'(cyc), 32'd7);
        chk("rol_strb", 32'(strb), 32'b00001);
        chk("rol_zero", 32'(z_zero), 32'd0);
        chk("rol_neg", 32'(z_neg), 32'd0);
        tick;

        // SHL by 32 clears everything
`ifdef SHIFT_RESULT_FLAGS_EN
        exp_zero_f = 1'b1;
`else
        exp_zero_f = 1'b0;
`endif
        do_op(3'd2, 32'h0000_FFFF, 32'd32, 0, cyc, nexec, strb);
        chk("shl32_z", z_out, 32'd0);
        chk("shl32_strb", 32'(strb), 32'b00100);
        chk("shl32_zero", 32'(z_zero), 32'(exp_zero_f));
        tick;

        // SHRA producing a negative result exercises z_neg
`ifdef SHIFT_RESULT_FLAGS_EN
        exp_neg_f = 1'b1;
`else
        exp_neg_f = 1'b0;
`endif
        do_op(3'd1, 32'h8000_0000, 32'd1, 0, cyc, nexec, strb);
        chk("neg_z", z_out, 32'hC000_0000);
        chk("neg_flag", 32'(z_neg), 32'(exp_neg_f));
        chk("neg_zero", 32'(z_zero), 32'd0);
        tick;

        // Illegal op
        op = 3'd7;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        chk("ill_ready", 32'(bus_ready), 32'd0);
        chk("ill_strb", 32'({SHR, SHRA, SHL, ROR, ROL}), 32'd0);
        tick;
        chk("ill_err_1cyc", 32'(err), 32'd0);
        chk("ill_busy2", 32'(busy), 32'd0);
        chk("ill_z", z_out, 32'hC000_0000);

        // Abort in EXEC of ROR
        op = 3'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        bus_valid = 1'b1;
        bus_in = 32'h0000_0012;
        tick;
        bus_in = 32'd4;
        tick;
        bus_valid = 1'b0;
        chk("abort_ror_strb", 32'(ROR), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_z", z_out, 32'hC000_0000);
        tick;
        chk("abort_done2", 32'(done), 32'd0);

        // Asynchronous clr in LOAD_B
        op = 3'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        bus_valid = 1'b1;
        bus_in = 32'h1234_5678;
        tick;
        bus_valid = 1'b0;
        chk("pre_clr_ready", 32'(bus_ready), 32'd1);
        #3;
        clr = 1'b1;
        #1;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_ready", 32'(bus_ready), 32'd0);
        chk("clr_sha", sh_a, 32'd0);
        chk("clr_z", z_out, 32'd0);
        chk("clr_zneg", 32'(z_neg), 32'd0);
        #1;
        clr = 1'b0;
        tick;
        do_op(3'd0, 32'h0000_0010, 32'd1, 0, cyc, nexec, strb);
        chk("post_clr_z", z_out, 32'h0000_0008);
        chk("post_clr_lat", 32'(cyc), 32'd4);
        tick;

        // EXEC_CYCLES=3 instance: ROR 1 by 1
        op = 3'd3;
        bus_valid = 1'b1;
        bus_in = 32'd1;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        nexec = 0;
        done_at = 0;
        for (int c = 1; c <= 12; c++) begin
            if (ROR2) nexec++;
            if (done2 && done_at == 0) done_at = c;
            tick;
        end
        bus_valid = 1'b0;
        chk("ex3_nexec", 32'(nexec), 32'd3);
        chk("ex3_done_at", 32'(done_at), 32'd6);
        chk("ex3_z", z_out2, 32'h8000_0000);
        chk("ex3_other_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
